key_expansion: RTL and testbench
================================

# key_expansion

Iterative AES key-schedule generator that expands an NK-word cipher key into NR+1 round keys of NB words each. It stores the round keys and serves one per cycle to addRoundKey's `key_schedule_in`, indexed by the same round number the round datapath uses. The block sits directly upstream of addRoundKey and runs once per key load; the cipher datapath waits on `key_ready_out` before starting.

## Interface
- `NK__KEY_LENGTH`, 8: cipher key length in 32-bit words.
- `NR__ROUNDS`, 14: number of cipher rounds.
- `NB__BLOCK_LENGTH_IN_TEXT`, 4: block length in 32-bit words.
- `clock_in` input 1: single clock, rising edge.
- `reset_n_in` input 1: asynchronous, active-low reset.
- `cipher_key_in` input NK*32: cipher key. The MSB word is w[0] (FIPS-197 byte order).
- `key_load_in` input 1: start expansion. Sampled only in IDLE or DONE.
- `round_number_in` input 4: round key select, 0..NR.
- `busy_out` output 1: high while EXPAND is active.
- `key_ready_out` output 1: high in DONE. The full schedule is valid.
- `round_key_out` output NB*32: selected round key, registered. {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
- `round_key_valid_out` output 1: `round_key_out` holds a valid key.

## Operation
- Word store: NB*(NR+1) = 60 words of 32 bits each.
- FSM has three states: IDLE, EXPAND, DONE.
  - IDLE → EXPAND on `key_load_in`.
  - EXPAND → DONE after the last word is written.
  - DONE → EXPAND on `key_load_in`. This re-keys the block, and `key_ready_out` drops on that same edge.
  - `key_load_in` during EXPAND is ignored, and the key in progress completes.
- Load edge:
  - w[0..NK-1] ← `cipher_key_in`.
  - Word index i ← NK.
- EXPAND, one word per cycle, for i = NK..59:
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK], 24'h0}.
  - Else if NK > 6 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40. Rcon is extended through 36 so that NK = 4 and NK = 6 configurations also work.
- Index counter width is 6 bits. It never wraps, and it stops at 59.
- Read port, registered on every edge:
  - `round_key_valid_out` ← `key_ready_out` && (`round_number_in` ≤ NR).
  - `round_key_out` ← the selected key when that condition holds; otherwise all zeros.
- Reset, at any time including mid-expansion:
  - State → IDLE.
  - `busy_out`, `key_ready_out`, `round_key_valid_out` → 0.
  - `round_key_out` → 0.
  - Index → NK.

## Timing
- Let E0 be the edge that samples `key_load_in`.
  - At E0: `busy_out` goes to 1 and `key_ready_out` goes to 0.
  - Edges E1..E52 write w[8]..w[59].
  - At E52: state becomes DONE, `busy_out` = 0, `key_ready_out` = 1.
- Expansion latency is 60 − NK cycles, which is 52 for the defaults.
- Read latency is 1 cycle: `round_number_in` sampled at edge E appears on `round_key_out` after E.
- On a re-key, the first edge after the load shows `round_key_valid_out` = 0.
- Throughput: one round key per cycle in DONE, with an arbitrary round order.

## Configuration
- Macro: `KEY_SCHED_ZEROIZE_EN`.
- Defined:
  - The word store has asynchronous reset to 0.
  - An extra input `key_zeroize_in` (1 bit) synchronously clears all 60 words and forces IDLE on the next edge.
  - Zeroize has priority over `key_load_in`.
  - Outputs follow reset values one cycle later.
- Undefined:
  - The port is absent.
  - The word store has no reset, so contents after reset are undefined but never exposed, because valid stays 0 until DONE.

## Structure
- Shared package `aes_pkg` contains:
  - NK/NR/NB defaults.
  - The Rcon table as a constant function.
  - The FSM state typedef.
  - The word-count function NB*(NR+1).
- Sub-module `aes_sbox`: combinational 8→8 forward S-box.
  - Four instances form SubWord.
  - The same module is reused by the SubBytes stage.

## Test plan
- Reset mid-EXPAND (assert at cycle 20) → all outputs 0 and state IDLE. A fresh load then completes in 52 cycles.
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - `key_ready_out` rises exactly 52 cycles after the load edge.
  - w[8] = 9ba35411.
  - Round 0 = 603deb1015ca71be2b73aef0857d7781.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
- Read all rounds 14 down to 0 back-to-back → each key appears 1 cycle after its select, with valid high throughout.
- `round_number_in` = 15 in DONE → `round_key_out` = 0 and `round_key_valid_out` = 0 on the next cycle.
- Second `key_load_in` during EXPAND → ignored and the first key completes. A load in DONE with key all-zeros → round 1 = 00000000000000000000000000000000? Not applicable: check instead that round 2 = 62636363626363636263636362636363.
- With `KEY_SCHED_ZEROIZE_EN`: zeroize in DONE → ready 0, and a subsequent load still yields correct keys.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions: key-schedule size defaults, the
//                Rcon round-constant generator, the key-expansion FSM state
//                type and the word-count helper NB*(NR+1).
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int NK_DEFAULT = 8;
    localparam int NR_DEFAULT = 14;
    localparam int NB_DEFAULT = 4;

    // Rcon is generated up to this index so that NK = 4 and NK = 6 builds
    // have every constant they can ask for.
    localparam int RCON_MAX = 36;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_e;

    function automatic int word_count(input int nb, input int nr);
        return nb * (nr + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rcon[idx] = x^(idx-1) in GF(2^8). Index 0 and indices past RCON_MAX
    // return zero.
    function automatic logic [7:0] rcon(input logic [5:0] idx);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 2; k <= RCON_MAX; k++) begin
            if (k <= int'(idx)) r = xtime(r);
        end
        if (idx == 6'd0 || int'(idx) > RCON_MAX) r = 8'h00;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box, 8 bits in, 8 bits out.
//                Used four times to build SubWord in the key schedule and
//                by the SubBytes stage of the round datapath.
//  Ports       : data_i [7:0]  byte to substitute
//                data_o [7:0]  substituted byte
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SBOX_TABLE[(11'd2047 - {data_i, 3'b000}) -: 8];

endmodule
`default_nettype wire

// File: rtl/key_expansion.sv
`default_nettype none
// ============================================================================
//  Module      : key_expansion
//  Description : Iterative AES key schedule. Loads an NK-word cipher key,
//                generates one schedule word per cycle until all NB*(NR+1)
//                words are stored, then serves one registered round key per
//                cycle selected by round_number_in.
//  Ports       : clock_in             rising-edge clock
//                reset_n_in           asynchronous active-low reset
//                cipher_key_in        NK*32-bit key, w[0] in the MSBs
//                key_load_in          start expansion (IDLE/DONE only)
//                key_zeroize_in       (KEY_SCHED_ZEROIZE_EN only) wipe store
//                round_number_in      round key select 0..NR
//                busy_out             expansion in progress
//                key_ready_out        full schedule valid
//                round_key_out        registered round key, w[NB*r] in MSBs
//                round_key_valid_out  round_key_out holds a valid key
//  Config      : KEY_SCHED_ZEROIZE_EN adds key_zeroize_in and an
//                asynchronously reset word store.
//  Revision    : 1.0  initial release
// ============================================================================
module key_expansion
    import aes_pkg::*;
#(
    parameter int NK__KEY_LENGTH           = NK_DEFAULT,
    parameter int NR__ROUNDS               = NR_DEFAULT,
    parameter int NB__BLOCK_LENGTH_IN_TEXT = NB_DEFAULT
) (
    input  logic                                  clock_in,
    input  logic                                  reset_n_in,
    input  logic [NK__KEY_LENGTH*32-1:0]          cipher_key_in,
    input  logic                                  key_load_in,
`ifdef KEY_SCHED_ZEROIZE_EN
    input  logic                                  key_zeroize_in,
`endif
    input  logic [3:0]                            round_number_in,
    output logic                                  busy_out,
    output logic                                  key_ready_out,
    output logic [NB__BLOCK_LENGTH_IN_TEXT*32-1:0] round_key_out,
    output logic                                  round_key_valid_out
);

    localparam int          NW       = word_count(NB__BLOCK_LENGTH_IN_TEXT, NR__ROUNDS);
    localparam logic [5:0]  LAST_IDX = 6'(NW - 1);
    localparam logic [5:0]  NK_IDX   = 6'(NK__KEY_LENGTH);
    localparam logic [5:0]  NB_IDX   = 6'(NB__BLOCK_LENGTH_IN_TEXT);
    localparam logic [3:0]  NR_SEL   = 4'(NR__ROUNDS);

    ks_state_e   state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] w_q [NW];

    logic        load_fire;
    logic        zeroize;
    logic [5:0]  idx_mod;
    logic [31:0] prev_word, back_word, sub_in, sub_out, temp_word, new_word;
    logic [5:0]  rd_base;
    logic        rd_ok;
    logic [NB__BLOCK_LENGTH_IN_TEXT*32-1:0] rk_sel, rk_q;
    logic        rk_valid_q;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign zeroize = key_zeroize_in;
`else
    assign zeroize = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next state. Zeroize overrides everything, including a load.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_fire = 1'b0;
        case (state_q)
            KS_IDLE, KS_DONE: begin
                if (key_load_in) begin
                    load_fire = 1'b1;
                    state_d   = KS_EXPAND;
                    idx_d     = NK_IDX;
                end
            end
            KS_EXPAND: begin
                // The index parks on the last word; it never wraps.
                if (idx_q == LAST_IDX) state_d = KS_DONE;
                else                   idx_d   = idx_q + 6'd1;
            end
            default: state_d = KS_IDLE;
        endcase
        if (zeroize) begin
            state_d   = KS_IDLE;
            idx_d     = NK_IDX;
            load_fire = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Schedule word generation for w[idx_q]
    // ------------------------------------------------------------------
    assign idx_mod   = idx_q % NK_IDX;
    assign prev_word = w_q[idx_q - 6'd1];
    assign back_word = w_q[idx_q - NK_IDX];
    // RotWord only feeds the S-boxes on the once-per-key-length step.
    assign sub_in    = (idx_mod == 6'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data_i (sub_in[8*b +: 8]),
            .data_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_word = prev_word;
        if (idx_mod == 6'd0) begin
            temp_word = sub_out ^ {rcon(idx_q / NK_IDX), 24'h000000};
        end else if (NK__KEY_LENGTH > 6 && idx_mod == 6'd4) begin
            temp_word = sub_out;
        end
    end

    assign new_word = back_word ^ temp_word;

    // ------------------------------------------------------------------
    // Word store
    // ------------------------------------------------------------------
`ifdef KEY_SCHED_ZEROIZE_EN
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else if (zeroize) begin
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else if (load_fire) begin
            for (int k = 0; k < NK__KEY_LENGTH; k++)
                w_q[k] <= cipher_key_in[(NK__KEY_LENGTH-1-k)*32 +: 32];
        end else if (state_q == KS_EXPAND) begin
            w_q[idx_q] <= new_word;
        end
    end
`else
    // No reset: contents are never visible until the schedule reaches DONE.
    always_ff @(posedge clock_in) begin
        if (load_fire) begin
            for (int k = 0; k < NK__KEY_LENGTH; k++)
                w_q[k] <= cipher_key_in[(NK__KEY_LENGTH-1-k)*32 +: 32];
        end else if (state_q == KS_EXPAND) begin
            w_q[idx_q] <= new_word;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    assign rd_ok   = key_ready_out && (round_number_in <= NR_SEL);
    assign rd_base = 6'(round_number_in) * NB_IDX;

    always_comb begin
        rk_sel = '0;
        for (int k = 0; k < NB__BLOCK_LENGTH_IN_TEXT; k++)
            rk_sel[(NB__BLOCK_LENGTH_IN_TEXT-1-k)*32 +: 32] = w_q[rd_base + 6'(k)];
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= KS_IDLE;
            idx_q      <= NK_IDX;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rk_valid_q <= rd_ok;
            rk_q       <= rd_ok ? rk_sel : '0;
        end
    end

    assign busy_out            = (state_q == KS_EXPAND);
    assign key_ready_out       = (state_q == KS_DONE);
    assign round_key_out       = rk_q;
    assign round_key_valid_out = rk_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_expansion
//  Description : Self-checking bench for key_expansion. A reference key
//                schedule is built from a mathematically derived S-box
//                (GF(2^8) inverse plus affine map); known FIPS-197 vectors,
//                random keys and multi-cycle corner cases are compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_expansion;

    localparam int NK = 8;
    localparam int NR = 14;
    localparam int NB = 4;
    localparam int NW = 60;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key;
    logic         load;
    logic [3:0]   rnd;
    logic         busy, ready, rkv;
    logic [127:0] rk;
`ifdef KEY_SCHED_ZEROIZE_EN
    logic         zero;
`endif

    always #5 clk = ~clk;

    key_expansion #(
        .NK__KEY_LENGTH           (NK),
        .NR__ROUNDS               (NR),
        .NB__BLOCK_LENGTH_IN_TEXT (NB)
    ) dut (
        .clock_in            (clk),
        .reset_n_in          (rst_n),
        .cipher_key_in       (key),
        .key_load_in         (load),
`ifdef KEY_SCHED_ZEROIZE_EN
        .key_zeroize_in      (zero),
`endif
        .round_number_in     (rnd),
        .busy_out            (busy),
        .key_ready_out       (ready),
        .round_key_out       (rk),
        .round_key_valid_out (rkv)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] ref_w  [NW];

    typedef struct {
        logic [255:0] key;
        logic [3:0]   round;
        logic [127:0] exp_key;
        logic         exp_valid;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic ref_expand(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < NK; i++) ref_w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = NK; i < NW; i++) begin
            t = ref_w[i-1];
            if (i % NK == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (i % NK == 4) begin
                t = sub_word(t);
            end
            ref_w[i] = ref_w[i-NK] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_round(input int r);
        if (r > NR) return '0;
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Load a key and return the number of edges from the load edge until
    // key_ready_out is seen (0 if it never rises).
    task automatic load_key(input logic [255:0] k, output int lat);
        key  = k;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("busy_after_load", 128'(busy), 128'd1);
        check("ready_after_load", 128'(ready), 128'd0);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1) check("valid_first_edge", 128'(rkv), 128'd0);
            if (ready) begin
                lat = n;
                break;
            end
        end
        check("latency", 128'(lat), 128'd52);
    endtask

    task automatic read_round(input logic [3:0] r, output logic [127:0] k, output logic v);
        rnd = r;
        @(posedge clk); #1;
        k = rk;
        v = rkv;
    endtask

    task automatic check_random_reads(input int count);
        logic [127:0] got;
        logic         gv;
        int           r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 15);
            read_round(4'(r), got, gv);
            check("rand_round_key", got, ref_round(r));
            check("rand_round_valid", 128'(gv), (r <= NR) ? 128'd1 : 128'd0);
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        logic [127:0] got;
        logic         gv;
        logic [255:0] cur_key;
        logic         have_key;
        logic [255:0] ka, kb;

        build_sbox();

        vecs[0] = '{KEY_A3, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b1};
        vecs[1] = '{KEY_A3, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b1};
        vecs[2] = '{KEY_A3, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1};
        vecs[3] = '{KEY_A3, 4'd15, 128'h0, 1'b0};
        vecs[4] = '{256'h0, 4'd2,  128'h62636363626363636263636362636363, 1'b1};
        vecs[5] = '{256'h0, 4'd0,  128'h0, 1'b1};
        vecs[6] = '{256'h0, 4'd15, 128'h0, 1'b0};

        rst_n = 1'b0;
        key   = '0;
        load  = 1'b0;
        rnd   = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
        zero  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {125'd0, busy, ready, rkv}, 128'd0);
        check("reset_key", rk, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 A.3: w[8], then all rounds back-to-back descending
        ref_expand(KEY_A3);
        load_key(KEY_A3, lat);
        read_round(4'd2, got, gv);
        check("a3_w8", {96'd0, got[127:96]}, {96'd0, 32'h9ba35411});
        for (int r = 14; r >= 0; r--) begin
            rnd = 4'(r);
            @(posedge clk); #1;
            check("b2b_key", rk, ref_round(r));
            check("b2b_valid", 128'(rkv), 128'd1);
        end
        read_round(4'd15, got, gv);
        check("round15_key", got, 128'd0);
        check("round15_valid", 128'(gv), 128'd0);

        // Table of fixed vectors
        have_key = 1'b0;
        cur_key  = '0;
        for (int i = 0; i < 7; i++) begin
            if (!have_key || cur_key != vecs[i].key) begin
                load_key(vecs[i].key, lat);
                cur_key  = vecs[i].key;
                have_key = 1'b1;
            end
            read_round(vecs[i].round, got, gv);
            check("table_key", got, vecs[i].exp_key);
            check("table_valid", 128'(gv), 128'(vecs[i].exp_valid));
        end

        // Random keys against the model
        for (int t = 0; t < 4; t++) begin
            ka = rand_key();
            ref_expand(ka);
            load_key(ka, lat);
            check_random_reads(20);
        end

        // A second load during EXPAND is ignored
        ka = rand_key();
        kb = ~ka;
        ref_expand(ka);
        key  = ka;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 10) begin
                key  = kb;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
        load = 1'b0;
        check("ignored_load_latency", 128'(lat), 128'd52);
        check_random_reads(16);

        // Reset 20 cycles into expansion
        ka = rand_key();
        key  = ka;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midreset_flags", {125'd0, busy, ready, rkv}, 128'd0);
        check("midreset_key", rk, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_idle", {126'd0, busy, ready}, 128'd0);
        ka = rand_key();
        ref_expand(ka);
        load_key(ka, lat);
        check_random_reads(10);

`ifdef KEY_SCHED_ZEROIZE_EN
        // Zeroize in DONE, with a simultaneous load that must lose
        rnd  = 4'd3;
        zero = 1'b1;
        load = 1'b1;
        @(posedge clk); #1;
        zero = 1'b0;
        load = 1'b0;
        check("zeroize_flags", {126'd0, busy, ready}, 128'd0);
        @(posedge clk); #1;
        check("zeroize_valid", 128'(rkv), 128'd0);
        check("zeroize_key", rk, 128'd0);
        ka = rand_key();
        ref_expand(ka);
        load_key(ka, lat);
        check_random_reads(10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
